// File: rtl/mem_access_ctrl.sv
// -----------------------------------------------------------------------------
// mem_access_ctrl
// Initiator-side memory interface between the Mini SRC datapath and a
// single-port RAM with combinational read data. One read or write request is
// accepted per req/done handshake. The address (MAR) and write data (MDR) are
// frozen for the whole access, and WAIT_CYCLES wait states are inserted before
// the write strobe is driven or the read data is sampled. Addresses that do
// not fit in the RAM are flagged and never reach the write strobe.
//
// Ports
//   clk         system clock, all state changes on the rising edge
//   rst_n       asynchronous active-low reset
//   req         request strobe, sampled only in IDLE
//   rd_wr_n     1 = read, 0 = write, sampled with req
//   cpu_addr    32-bit word address, sampled with req
//   cpu_wdata   write data, sampled with req
//   busy        high whenever the FSM is not in IDLE
//   done        one-cycle completion pulse (DONE state)
//   addr_err    high with done when the latched address was out of range
//   rd_data     last read result, held until the next read completes
//   mem_r_addr  RAM read address  (MAR low bits)
//   mem_w_addr  RAM write address (MAR low bits)
//   mem_w_data  RAM write data    (MDR)
//   mem_wr_en   RAM write strobe, one cycle per valid write
//   mem_r_data  RAM combinational read data
// -----------------------------------------------------------------------------
module mem_access_ctrl #(
  parameter int depth       = 9,
  parameter int width       = 32,
  parameter int WAIT_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req,
  input  logic             rd_wr_n,
  input  logic [31:0]      cpu_addr,
  input  logic [width-1:0] cpu_wdata,
  output logic             busy,
  output logic             done,
  output logic             addr_err,
  output logic [width-1:0] rd_data,
  output logic [depth-1:0] mem_r_addr,
  output logic [depth-1:0] mem_w_addr,
  output logic [width-1:0] mem_w_data,
  output logic             mem_wr_en,
  input  logic [width-1:0] mem_r_data
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  state_t           state_r;
  state_t           state_nxt_s;
  logic [depth-1:0] mar_r;
  logic [width-1:0] mdr_r;
  logic [width-1:0] rd_data_r;
  logic [3:0]       cnt_r;
  logic             op_r;
  logic             err_r;
  logic             access_last_s;

  // Any address bit above the RAM index range makes the request invalid.
  function automatic logic addr_out_of_range(input logic [31:0] addr);
    return (addr >> depth) != 32'd0;
  endfunction

  // The final ACCESS cycle is the one where the wait counter has run out.
  assign access_last_s = (state_r == ACCESS) && (cnt_r == 4'd0);

  // Next-state logic for the IDLE -> ACCESS -> DONE -> IDLE handshake.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (req) begin
          state_nxt_s = ACCESS;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ACCESS: begin
        if (access_last_s) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = ACCESS;
        end
      end
      DONE:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Request latch, wait counter and read-data capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mar_r     <= '0;
      mdr_r     <= '0;
      rd_data_r <= '0;
      cnt_r     <= 4'd0;
      op_r      <= 1'b0;
      err_r     <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (req) begin
            mar_r <= cpu_addr[depth-1:0];
            mdr_r <= cpu_wdata;
            op_r  <= rd_wr_n;
            err_r <= addr_out_of_range(cpu_addr);
            cnt_r <= WAIT_INIT;
          end
        end
        ACCESS: begin
          if (cnt_r != 4'd0) begin
            cnt_r <= cnt_r - 4'd1;
          end else if (op_r) begin
            // An out-of-range read returns zero rather than aliased RAM data.
            rd_data_r <= err_r ? '0 : mem_r_data;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Status and RAM-side outputs decode straight from registered state so
  // that an asynchronous reset clears them without waiting for a clock edge.
  assign busy       = (state_r != IDLE);
  assign done       = (state_r == DONE);
  assign addr_err   = (state_r == DONE) && err_r;
  assign mem_wr_en  = access_last_s && !op_r && !err_r;
  assign rd_data    = rd_data_r;
  assign mem_r_addr = mar_r;
  assign mem_w_addr = mar_r;
  assign mem_w_data = mdr_r;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mem_access_ctrl
// Two instances: u0 with WAIT_CYCLES=1 and u1 with WAIT_CYCLES=0, each
// attached to its own behavioural RAM. Stimulus tasks push expected completions
// and expected write strobes into queues; a negedge monitor pops and compares.
// -----------------------------------------------------------------------------
module tb_mem_access_ctrl;

  typedef struct packed {
    logic [31:0] cyc;
    logic        err;
    logic [31:0] rd;
  } exp_t;

  typedef struct packed {
    logic [31:0] cyc;
    logic [8:0]  a;
    logic [31:0] d;
  } wexp_t;

  logic        clk = 1'b0;
  int unsigned cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  exp_t  q0[$];
  exp_t  q1[$];
  wexp_t wq0[$];
  wexp_t wq1[$];

  logic        rst0_n, req0, rw0, busy0, done0, err0, we0;
  logic [31:0] addr0, wd0, rdd0, wdo0, rdata0;
  logic [8:0]  ra0, wa0;
  logic        rst1_n, req1, rw1, busy1, done1, err1, we1;
  logic [31:0] addr1, wd1, rdd1, wdo1, rdata1;
  logic [8:0]  ra1, wa1;

  logic [31:0] ram0 [0:511];
  logic [31:0] ram1 [0:511];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  mem_access_ctrl #(.depth(9), .width(32), .WAIT_CYCLES(1)) u0 (
    .clk(clk), .rst_n(rst0_n), .req(req0), .rd_wr_n(rw0), .cpu_addr(addr0),
    .cpu_wdata(wd0), .busy(busy0), .done(done0), .addr_err(err0),
    .rd_data(rdd0), .mem_r_addr(ra0), .mem_w_addr(wa0), .mem_w_data(wdo0),
    .mem_wr_en(we0), .mem_r_data(rdata0)
  );

  mem_access_ctrl #(.depth(9), .width(32), .WAIT_CYCLES(0)) u1 (
    .clk(clk), .rst_n(rst1_n), .req(req1), .rd_wr_n(rw1), .cpu_addr(addr1),
    .cpu_wdata(wd1), .busy(busy1), .done(done1), .addr_err(err1),
    .rd_data(rdd1), .mem_r_addr(ra1), .mem_w_addr(wa1), .mem_w_data(wdo1),
    .mem_wr_en(we1), .mem_r_data(rdata1)
  );

  // Behavioural single-port RAMs: combinational read, write on the clock edge.
  assign rdata0 = ram0[ra0];
  assign rdata1 = ram1[ra1];

  always @(posedge clk) begin
    if (we0) ram0[wa0] <= wdo0;
    if (we1) ram1[wa1] <= wdo1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic drive(input int sel, input logic r, input logic rw,
                       input logic [31:0] a, input logic [31:0] d);
    if (sel == 0) begin
      req0 = r; rw0 = rw; addr0 = a; wd0 = d;
    end else begin
      req1 = r; rw1 = rw; addr1 = a; wd1 = d;
    end
  endtask

  function automatic logic busy_of(input int sel);
    return (sel == 0) ? busy0 : busy1;
  endfunction

  task automatic push_exp(input int sel, input logic [31:0] c, input logic e,
                          input logic [31:0] r);
    exp_t x;
    x.cyc = c; x.err = e; x.rd = r;
    if (sel == 0) q0.push_back(x);
    else          q1.push_back(x);
  endtask

  task automatic push_w(input int sel, input logic [31:0] c, input logic [8:0] a,
                        input logic [31:0] d);
    wexp_t x;
    x.cyc = c; x.a = a; x.d = d;
    if (sel == 0) wq0.push_back(x);
    else          wq1.push_back(x);
  endtask

  // Pop and compare whenever an instance shows done or a write strobe.
  task automatic mon(input int sel, input logic d, input logic ae, input logic [31:0] rd,
                     input logic we, input logic [8:0] wa, input logic [31:0] wd);
    exp_t  e;
    wexp_t w;
    if (d) begin
      if ((sel == 0 && q0.size() == 0) || (sel == 1 && q1.size() == 0)) begin
        n_checks++; n_fail++;
        $display("FAIL unexpected_done u%0d: got done=1 expected done=0 (cycle %0d)", sel, cyc);
      end else begin
        if (sel == 0) e = q0.pop_front();
        else          e = q1.pop_front();
        chk("done_cycle", cyc, e.cyc);
        chk("addr_err", {31'd0, ae}, {31'd0, e.err});
        chk("rd_data", rd, e.rd);
      end
    end
    if (we) begin
      if ((sel == 0 && wq0.size() == 0) || (sel == 1 && wq1.size() == 0)) begin
        n_checks++; n_fail++;
        $display("FAIL unexpected_wr_en u%0d: got wr_en=1 addr %h expected wr_en=0 (cycle %0d)",
                 sel, wa, cyc);
      end else begin
        if (sel == 0) w = wq0.pop_front();
        else          w = wq1.pop_front();
        chk("wr_cycle", cyc, w.cyc);
        chk("wr_addr", {23'd0, wa}, {23'd0, w.a});
        chk("wr_data", wd, w.d);
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0, done0, err0, rdd0, we0, wa0, wdo0);
    mon(1, done1, err1, rdd1, we1, wa1, wdo1);
  end

  // One isolated request: predict completion and strobe timing, scramble the
  // cpu_* inputs after acceptance, and count busy cycles until IDLE.
  task automatic txn(input int sel, input logic rw, input logic [31:0] a,
                     input logic [31:0] d, input logic e, input logic [31:0] er);
    int unsigned k;
    int          w;
    int          nb;
    w = (sel == 0) ? 1 : 0;
    @(negedge clk);
    drive(sel, 1'b1, rw, a, d);
    @(posedge clk);
    #1;
    k = cyc;
    push_exp(sel, k + 1 + w, e, er);
    if (!rw && !e) push_w(sel, k + w, a[8:0], d);
    @(negedge clk);
    drive(sel, 1'b0, ~rw, a ^ 32'h0000_00FF, ~d);
    nb = 0;
    for (int t = 0; t < 20; t++) begin
      if (busy_of(sel)) begin
        nb++;
        @(negedge clk);
      end else begin
        break;
      end
    end
    chk("busy_cycles", nb, 2 + w);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic        hrw [4];
    logic [31:0] ha  [4];
    logic [31:0] hd  [4];
    logic [31:0] her [4];
    int unsigned k0;

    for (int i = 0; i < 512; i++) begin
      ram0[i] <= 32'hC000_0000 | 32'(i);
      ram1[i] <= 32'h5A5A_0000 | 32'(i);
    end
    rst0_n = 1'b1; rst1_n = 1'b1;
    drive(0, 1'b0, 1'b1, 32'd0, 32'd0);
    drive(1, 1'b0, 1'b1, 32'd0, 32'd0);
    #2;
    rst0_n = 1'b0; rst1_n = 1'b0;
    #1;
    chk("rst_busy0", {31'd0, busy0}, 32'd0);
    chk("rst_done0", {31'd0, done0}, 32'd0);
    chk("rst_addr_err0", {31'd0, err0}, 32'd0);
    chk("rst_wr_en0", {31'd0, we0}, 32'd0);
    chk("rst_rd_data0", rdd0, 32'd0);
    chk("rst_w_addr0", {23'd0, wa0}, 32'd0);
    chk("rst_w_data0", wdo0, 32'd0);
    chk("rst_busy1", {31'd0, busy1}, 32'd0);
    chk("rst_rd_data1", rdd1, 32'd0);
    repeat (3) @(negedge clk);
    rst0_n = 1'b1; rst1_n = 1'b1;
    repeat (2) @(negedge clk);

    // Write then read back, WAIT_CYCLES=1.
    txn(0, 1'b0, 32'h0000_0005, 32'hDEAD_BEEF, 1'b0, 32'h0000_0000);
    chk("ram0_5", ram0[5], 32'hDEAD_BEEF);
    txn(0, 1'b1, 32'h0000_0005, 32'h0000_0000, 1'b0, 32'hDEAD_BEEF);

    // Out-of-range write and read.
    txn(0, 1'b0, 32'h0000_0200, 32'h1111_1111, 1'b1, 32'hDEAD_BEEF);
    chk("ram0_0_untouched", ram0[0], 32'hC000_0000);
    txn(0, 1'b1, 32'h8000_0005, 32'h0000_0000, 1'b1, 32'h0000_0000);

    // req held high with alternating write/read: one accept per 4 cycles.
    hrw[0] = 1'b0; ha[0] = 32'h10; hd[0] = 32'hAAAA_0001; her[0] = 32'h0000_0000;
    hrw[1] = 1'b1; ha[1] = 32'h10; hd[1] = 32'h0000_0000; her[1] = 32'hAAAA_0001;
    hrw[2] = 1'b0; ha[2] = 32'h11; hd[2] = 32'h5555_0002; her[2] = 32'hAAAA_0001;
    hrw[3] = 1'b1; ha[3] = 32'h11; hd[3] = 32'h0000_0000; her[3] = 32'h5555_0002;
    @(negedge clk);
    drive(0, 1'b1, hrw[0], ha[0], hd[0]);
    @(posedge clk);
    #1;
    k0 = cyc;
    for (int i = 0; i < 4; i++) begin
      push_exp(0, k0 + 4 * i + 2, 1'b0, her[i]);
      if (!hrw[i]) push_w(0, k0 + 4 * i + 1, ha[i][8:0], hd[i]);
      @(negedge clk);
      if (i < 3) begin
        drive(0, 1'b1, hrw[i + 1], ha[i + 1], hd[i + 1]);
        repeat (4) @(posedge clk);
      end else begin
        drive(0, 1'b0, 1'b1, 32'd0, 32'd0);
      end
    end
    repeat (5) @(negedge clk);
    chk("ram0_10", ram0[16], 32'hAAAA_0001);
    chk("ram0_11", ram0[17], 32'h5555_0002);

    // Reset during a write's first ACCESS cycle.
    @(negedge clk);
    drive(0, 1'b1, 1'b0, 32'h0000_0020, 32'hFFFF_FFFF);
    @(posedge clk);
    #1;
    drive(0, 1'b0, 1'b0, 32'h0000_0020, 32'hFFFF_FFFF);
    chk("pre_rst_busy0", {31'd0, busy0}, 32'd1);
    rst0_n = 1'b0;
    #1;
    chk("mid_rst_busy0", {31'd0, busy0}, 32'd0);
    chk("mid_rst_wr_en0", {31'd0, we0}, 32'd0);
    chk("mid_rst_rd_data0", rdd0, 32'd0);
    repeat (2) @(negedge clk);
    rst0_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("ram0_20_untouched", ram0[32], 32'hC000_0020);
    chk("post_rst_rd_data0", rdd0, 32'd0);
    txn(0, 1'b1, 32'h0000_0010, 32'h0000_0000, 1'b0, 32'hAAAA_0001);

    // WAIT_CYCLES=0: top word must not wrap to address 0.
    txn(1, 1'b1, 32'h0000_01FF, 32'h0000_0000, 1'b0, 32'h5A5A_01FF);
    txn(1, 1'b0, 32'h0000_01FE, 32'h0F0F_0F0F, 1'b0, 32'h5A5A_01FF);
    chk("ram1_1fe", ram1[510], 32'h0F0F_0F0F);
    txn(1, 1'b1, 32'h0000_01FE, 32'h0000_0000, 1'b0, 32'h0F0F_0F0F);
    chk("ram1_0_untouched", ram1[0], 32'h5A5A_0000);

    repeat (4) @(negedge clk);
    chk("q0_drained", q0.size(), 32'd0);
    chk("q1_drained", q1.size(), 32'd0);
    chk("wq0_drained", wq0.size(), 32'd0);
    chk("wq1_drained", wq1.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
